// File: rtl/kf_ctrl_pkg.sv
// Shared types and constants for the Kalman filter phase sequencer.
package kf_ctrl_pkg;

   localparam int STATE_W         = 4;
   localparam int DEFAULT_TIMEOUT = 4000;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 4'd0,
      ST_INIT = 4'd1,
      ST_SP   = 4'd2,
      ST_CKG  = 4'd3,
      ST_MDI  = 4'd4,
      ST_SCU  = 4'd5,
      ST_SCO  = 4'd6,
      ST_END  = 4'd7,
      ST_ERR  = 4'd8
   } kf_seq_state_t;

   // True in the phases that wait on the datapath; these are busy and watched.
   function automatic logic is_phase(input kf_seq_state_t s);
      return (s != ST_IDLE) && (s != ST_END) && (s != ST_ERR);
   endfunction

endpackage

// File: rtl/kf_phase_watchdog.sv
// Per-phase cycle counter; flags expiry when a waiting phase overstays TIMEOUT cycles.
module kf_phase_watchdog
   import kf_ctrl_pkg::*;
#(
   parameter int TMO_W   = 12,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic active,
   output logic expired
);

   localparam logic [TMO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0] count;

   // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (active)
         count <= count + TMO_W'(1);
   end

   assign expired = (TIMEOUT != 0) && active && (count == LIMIT);

endmodule

// File: rtl/kf_sequencer.sv
// Kalman filter phase sequencer: per-phase enables, SCU lane join, iteration control, watchdog.
module kf_sequencer
   import kf_ctrl_pkg::*;
#(
   parameter int NUM_SCU = 2,
   parameter int ITER_W  = 16,
   parameter int TMO_W   = 12,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [ITER_W-1:0]  cfg_iter,
   input  logic               cfg_predict_only,
   input  logic               init_valid,
   input  logic               sp_done,
   input  logic               ckg_done,
   input  logic               mdi_valid,
   input  logic [NUM_SCU-1:0] scu_done,
   input  logic               sco_valid,
   input  logic               end_valid,
   output logic               en_init,
   output logic               en_sp,
   output logic               en_ckg,
   output logic               en_mdi,
   output logic               en_scu,
   output logic               en_sco,
   output logic               busy,
   output logic               finish,
   output logic               err_timeout,
   output logic [ITER_W-1:0]  iter_cnt,
   output logic [STATE_W-1:0] state_o
);

   kf_seq_state_t      state, next_state, iter_target;
   logic               start_d, start_rise, do_start;
   logic [ITER_W-1:0]  cfg_iter_q, iter_next;
   logic               predict_only_q;
   logic [NUM_SCU-1:0] lane_mask, lane_seen;
   logic               lanes_all, iter_done, last_iter;
   logic               wd_expired, wd_clear;

   assign start_rise = start & ~start_d;
   assign do_start   = start_rise & ~abort &
                       ((state == ST_IDLE) | (state == ST_END) | (state == ST_ERR));

   // A final lane pulse counts in the same cycle it arrives.
   assign lane_seen  = lane_mask | scu_done;
   assign lanes_all  = &lane_seen;

   assign iter_next  = iter_cnt + ITER_W'(1);
   assign last_iter  = (cfg_iter_q != '0) && (iter_next == cfg_iter_q);
   assign iter_target = (last_iter || end_valid) ? ST_END : ST_SP;
   assign iter_done  = ~abort &
                       (((state == ST_SP) & ~end_valid & sp_done & predict_only_q) |
                        ((state == ST_SCO) & sco_valid));

   // Predict-only SP->SP is a self-loop, so iteration completion also restarts the watchdog.
   assign wd_clear   = (next_state != state) | iter_done;

   kf_phase_watchdog #(
      .TMO_W   (TMO_W),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .active  (is_phase(state)),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // NOTE: next_state is defaulted before the case so every path assigns it and no latch is inferred.
   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: if (start_rise) next_state = ST_INIT;
            ST_INIT: begin
               if (init_valid)      next_state = ST_SP;
               else if (wd_expired) next_state = ST_ERR;
            end
            ST_SP: begin
               if (end_valid)       next_state = ST_END;
               else if (sp_done)    next_state = predict_only_q ? iter_target : ST_CKG;
               else if (wd_expired) next_state = ST_ERR;
            end
            ST_CKG: begin
               if (ckg_done)        next_state = ST_MDI;
               else if (wd_expired) next_state = ST_ERR;
            end
            ST_MDI: begin
               if (mdi_valid)       next_state = ST_SCU;
               else if (wd_expired) next_state = ST_ERR;
            end
            ST_SCU: begin
               if (lanes_all)       next_state = ST_SCO;
               else if (wd_expired) next_state = ST_ERR;
            end
            ST_SCO: begin
               if (sco_valid)       next_state = iter_target;
               else if (wd_expired) next_state = ST_ERR;
            end
            ST_END, ST_ERR: if (start_rise) next_state = ST_INIT;
            default: next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      en_init     = 1'b0;
      en_sp       = 1'b0;
      en_ckg      = 1'b0;
      en_mdi      = 1'b0;
      en_scu      = 1'b0;
      en_sco      = 1'b0;
      finish      = 1'b0;
      err_timeout = 1'b0;
      case (state)
         ST_INIT: en_init     = 1'b1;
         ST_SP:   en_sp       = 1'b1;
         ST_CKG:  en_ckg      = 1'b1;
         ST_MDI:  en_mdi      = 1'b1;
         ST_SCU:  en_scu      = 1'b1;
         ST_SCO:  en_sco      = 1'b1;
         ST_END:  finish      = 1'b1;
         ST_ERR:  err_timeout = 1'b1;
         default: ;
      endcase
   end

   assign busy    = is_phase(state);
   assign state_o = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         start_d <= 1'b0;
      else
         start_d <= start;
   end

   // Config is captured only when a run starts, so mid-run changes are invisible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_iter_q     <= '0;
         predict_only_q <= 1'b0;
      end else if (do_start) begin
         cfg_iter_q     <= cfg_iter;
         predict_only_q <= cfg_predict_only;
      end
   end

   // Outside SCU the mask sits at zero, so each SCU entry starts collecting afresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lane_mask <= '0;
      else if ((state == ST_SCU) && !abort)
         lane_mask <= lane_seen;
      else
         lane_mask <= '0;
   end

   // Abort leaves the count untouched so software can see how far the run got.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         iter_cnt <= '0;
      else if (do_start)
         iter_cnt <= '0;
      else if (iter_done)
         iter_cnt <= iter_next;
   end

endmodule

// File: tb/tb_kf_sequencer.sv
// Directed bench for kf_sequencer: phase order, SCU join, predict-only, watchdog, priorities, reset.
`timescale 1ns/1ps
module tb_kf_sequencer;
   import kf_ctrl_pkg::*;

   localparam int NUM_SCU = 2;
   localparam int ITER_W  = 16;
   localparam int TMO_W   = 12;
   localparam int TIMEOUT = 16;

   // Expected {en_init,en_sp,en_ckg,en_mdi,en_scu,en_sco,finish,err_timeout,busy}
   localparam logic [8:0] O_IDLE = 9'b000000000;
   localparam logic [8:0] O_INIT = 9'b100000001;
   localparam logic [8:0] O_SP   = 9'b010000001;
   localparam logic [8:0] O_CKG  = 9'b001000001;
   localparam logic [8:0] O_MDI  = 9'b000100001;
   localparam logic [8:0] O_SCU  = 9'b000010001;
   localparam logic [8:0] O_SCO  = 9'b000001001;
   localparam logic [8:0] O_END  = 9'b000000100;
   localparam logic [8:0] O_ERR  = 9'b000000010;

   localparam int W_INIT = 0, W_SP = 1, W_CKG = 2, W_MDI = 3, W_SCO = 4;

   logic               clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic [ITER_W-1:0]  cfg_iter = '0;
   logic               cfg_predict_only = 1'b0;
   logic               init_valid = 1'b0, sp_done = 1'b0, ckg_done = 1'b0, mdi_valid = 1'b0;
   logic [NUM_SCU-1:0] scu_done = '0;
   logic               sco_valid = 1'b0, end_valid = 1'b0;
   logic               en_init, en_sp, en_ckg, en_mdi, en_scu, en_sco;
   logic               busy, finish, err_timeout;
   logic [ITER_W-1:0]  iter_cnt;
   logic [STATE_W-1:0] state_o;

   int   vectors = 0;
   int   miscompares = 0;
   logic watch_po = 1'b0;
   logic po_seen = 1'b0;

   always #5 clk = ~clk;

   kf_sequencer #(
      .NUM_SCU (NUM_SCU),
      .ITER_W  (ITER_W),
      .TMO_W   (TMO_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .abort            (abort),
      .cfg_iter         (cfg_iter),
      .cfg_predict_only (cfg_predict_only),
      .init_valid       (init_valid),
      .sp_done          (sp_done),
      .ckg_done         (ckg_done),
      .mdi_valid        (mdi_valid),
      .scu_done         (scu_done),
      .sco_valid        (sco_valid),
      .end_valid        (end_valid),
      .en_init          (en_init),
      .en_sp            (en_sp),
      .en_ckg           (en_ckg),
      .en_mdi           (en_mdi),
      .en_scu           (en_scu),
      .en_sco           (en_sco),
      .busy             (busy),
      .finish           (finish),
      .err_timeout      (err_timeout),
      .iter_cnt         (iter_cnt),
      .state_o          (state_o)
   );

   // Sticky flag: any non-predict enable seen while a predict-only run is watched.
   always @(posedge clk) begin
      if (!watch_po)
         po_seen <= 1'b0;
      else if (en_ckg | en_mdi | en_scu | en_sco)
         po_seen <= 1'b1;
   end

   function automatic logic [8:0] outs();
      return {en_init, en_sp, en_ckg, en_mdi, en_scu, en_sco, finish, err_timeout, busy};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_state(input string tag, input kf_seq_state_t st, input logic [8:0] ov);
      check({tag, "_state"}, 32'(state_o), 32'(st));
      check({tag, "_outs"}, 32'(outs()), 32'(ov));
   endtask

   task automatic pulse_sig(input int which);
      case (which)
         W_INIT: init_valid = 1'b1;
         W_SP:   sp_done    = 1'b1;
         W_CKG:  ckg_done   = 1'b1;
         W_MDI:  mdi_valid  = 1'b1;
         default: sco_valid = 1'b1;
      endcase
      step(1);
      init_valid = 1'b0;
      sp_done    = 1'b0;
      ckg_done   = 1'b0;
      mdi_valid  = 1'b0;
      sco_valid  = 1'b0;
   endtask

   // Check entry, wait five cycles (state must hold), then fire the phase's done.
   task automatic run_phase(input string tag, input kf_seq_state_t st, input logic [8:0] ov,
                            input int which);
      check_state(tag, st, ov);
      step(5);
      check({tag, "_hold"}, 32'(state_o), 32'(st));
      pulse_sig(which);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   // Lane0 at SCU cycle 3, lane1 at cycle 7; SCO must follow lane1 by one cycle.
   task automatic scu_split(input string tag);
      check_state(tag, ST_SCU, O_SCU);
      step(3);
      scu_done = 2'b01;
      step(1);
      scu_done = 2'b00;
      step(3);
      check({tag, "_wait_lane1"}, 32'(state_o), 32'(ST_SCU));
      scu_done = 2'b10;
      step(1);
      scu_done = 2'b00;
   endtask

   task automatic scu_both(input string tag);
      check_state(tag, ST_SCU, O_SCU);
      scu_done = 2'b11;
      step(1);
      scu_done = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      // Reset state
      step(2);
      check_state("reset", ST_IDLE, O_IDLE);
      check("reset_iter", 32'(iter_cnt), 32'd0);
      rst = 1'b0;
      step(1);

      // Two full iterations
      cfg_iter = 16'd2;
      cfg_predict_only = 1'b0;
      start_pulse();
      run_phase("t1_init", ST_INIT, O_INIT, W_INIT);
      run_phase("t1_sp1", ST_SP, O_SP, W_SP);
      run_phase("t1_ckg1", ST_CKG, O_CKG, W_CKG);
      run_phase("t1_mdi1", ST_MDI, O_MDI, W_MDI);
      scu_split("t1_scu1");
      run_phase("t1_sco1", ST_SCO, O_SCO, W_SCO);
      check("t1_iter1", 32'(iter_cnt), 32'd1);
      run_phase("t1_sp2", ST_SP, O_SP, W_SP);
      run_phase("t1_ckg2", ST_CKG, O_CKG, W_CKG);
      run_phase("t1_mdi2", ST_MDI, O_MDI, W_MDI);
      scu_both("t1_scu2");
      run_phase("t1_sco2", ST_SCO, O_SCO, W_SCO);
      check_state("t1_end", ST_END, O_END);
      check("t1_iter2", 32'(iter_cnt), 32'd2);

      // Predict-only, three iterations
      cfg_iter = 16'd3;
      cfg_predict_only = 1'b1;
      start_pulse();
      watch_po = 1'b1;
      check("t3_iter0", 32'(iter_cnt), 32'd0);
      run_phase("t3_init", ST_INIT, O_INIT, W_INIT);
      run_phase("t3_sp1", ST_SP, O_SP, W_SP);
      check("t3_iter1", 32'(iter_cnt), 32'd1);
      run_phase("t3_sp2", ST_SP, O_SP, W_SP);
      check("t3_iter2", 32'(iter_cnt), 32'd2);
      run_phase("t3_sp3", ST_SP, O_SP, W_SP);
      check_state("t3_end", ST_END, O_END);
      check("t3_iter3", 32'(iter_cnt), 32'd3);
      check("t3_no_ckg_scu", 32'(po_seen), 32'd0);
      watch_po = 1'b0;

      // Watchdog expiry: ERR exactly 16 cycles after CKG entry
      cfg_iter = 16'd0;
      cfg_predict_only = 1'b0;
      start_pulse();
      run_phase("t4_init", ST_INIT, O_INIT, W_INIT);
      run_phase("t4_sp", ST_SP, O_SP, W_SP);
      check_state("t4_ckg", ST_CKG, O_CKG);
      step(15);
      check("t4_ckg_c15", 32'(state_o), 32'(ST_CKG));
      step(1);
      check_state("t4_err", ST_ERR, O_ERR);
      step(3);
      check("t4_err_hold", 32'(state_o), 32'(ST_ERR));
      start_pulse();
      check_state("t4_restart", ST_INIT, O_INIT);
      pulse_sig(W_INIT);
      run_phase("t4_sp2", ST_SP, O_SP, W_SP);
      // ckg_done on the expiry cycle wins over the timeout
      check_state("t4_ckg2", ST_CKG, O_CKG);
      step(15);
      pulse_sig(W_CKG);
      check_state("t4_done_wins", ST_MDI, O_MDI);
      pulse_sig(W_MDI);
      scu_both("t4_scu");
      // sco_valid with end_valid ends the run even with unlimited iterations
      check_state("t4_sco", ST_SCO, O_SCO);
      end_valid = 1'b1;
      pulse_sig(W_SCO);
      end_valid = 1'b0;
      check_state("t4_end", ST_END, O_END);
      check("t4_iter", 32'(iter_cnt), 32'd1);

      // end_valid beats sp_done in SP; no iteration counted
      start_pulse();
      pulse_sig(W_INIT);
      pulse_sig(W_SP);
      pulse_sig(W_CKG);
      pulse_sig(W_MDI);
      scu_both("t5_scu_a");
      pulse_sig(W_SCO);
      check("t5_iter_a", 32'(iter_cnt), 32'd1);
      check_state("t5_sp", ST_SP, O_SP);
      end_valid = 1'b1;
      pulse_sig(W_SP);
      end_valid = 1'b0;
      check_state("t5_end_prio", ST_END, O_END);
      check("t5_iter_prio", 32'(iter_cnt), 32'd1);

      // Abort in SCU with lane0 collected
      start_pulse();
      check("t5_iter_clr", 32'(iter_cnt), 32'd0);
      pulse_sig(W_INIT);
      pulse_sig(W_SP);
      pulse_sig(W_CKG);
      pulse_sig(W_MDI);
      scu_both("t5_scu_b");
      pulse_sig(W_SCO);
      pulse_sig(W_SP);
      pulse_sig(W_CKG);
      pulse_sig(W_MDI);
      check_state("t5_scu_c", ST_SCU, O_SCU);
      scu_done = 2'b01;
      step(1);
      scu_done = 2'b00;
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check_state("t5_abort", ST_IDLE, O_IDLE);
      check("t5_abort_iter", 32'(iter_cnt), 32'd1);

      // Re-run: lane1 alone must not complete the join
      start_pulse();
      pulse_sig(W_INIT);
      pulse_sig(W_SP);
      pulse_sig(W_CKG);
      pulse_sig(W_MDI);
      check_state("t5_scu_d", ST_SCU, O_SCU);
      scu_done = 2'b10;
      step(1);
      scu_done = 2'b00;
      check("t5_mask_cleared", 32'(state_o), 32'(ST_SCU));
      scu_done = 2'b01;
      step(1);
      scu_done = 2'b00;
      check_state("t5_sco", ST_SCO, O_SCO);
      pulse_sig(W_SCO);
      check("t5_iter_d", 32'(iter_cnt), 32'd1);
      pulse_sig(W_SP);
      pulse_sig(W_CKG);

      // Reset asserted in MDI takes effect without a clock edge
      check_state("t6_mdi", ST_MDI, O_MDI);
      rst = 1'b1;
      #1;
      check_state("t6_rst", ST_IDLE, O_IDLE);
      check("t6_rst_iter", 32'(iter_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(1);

      // Start held high starts one run; a start pulse while busy is ignored
      cfg_iter = 16'd1;
      cfg_predict_only = 1'b1;
      start = 1'b1;
      step(1);
      check_state("t6_held", ST_INIT, O_INIT);
      step(2);
      check("t6_held_hold", 32'(state_o), 32'(ST_INIT));
      pulse_sig(W_INIT);
      check_state("t6_sp", ST_SP, O_SP);
      cfg_iter = 16'd0;
      cfg_predict_only = 1'b0;
      start = 1'b0;
      step(1);
      start_pulse();
      check("t6_busy_start", 32'(state_o), 32'(ST_SP));
      pulse_sig(W_SP);
      check_state("t6_end", ST_END, O_END);
      check("t6_iter", 32'(iter_cnt), 32'd1);
      step(2);
      check("t6_end_hold", 32'(state_o), 32'(ST_END));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
